// File: rtl/seq_gen.sv
// seq_gen: candidate-sequence generator for the LABS energy search.
// Enumerates a contiguous range of N-bit sequences starting at i_base and
// streams each one, together with its mask and offset, over a valid/ready
// handshake into the downstream energy-calculation stage.
//
// Optional feature macro: SEQ_GEN_SYM_SKIP_EN
//   defined   : complement symmetry is exploited, the index runs modulo
//               2^(N-1) so bit N-1 of o_seq is always 0.
//   undefined : the index runs modulo 2^N (full space).
module seq_gen #(
  parameter int SEQ_WIDTH = 30,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic [6:0]           i_len,
  input  logic [SEQ_WIDTH-1:0] i_base,
  input  logic [CNT_WIDTH-1:0] i_count,
  input  logic                 i_ready,
  output logic [SEQ_WIDTH-1:0] o_seq,
  output logic [SEQ_WIDTH-1:0] o_mask,
  output logic [6:0]           o_offset,
  output logic                 o_valid,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_err,
  output logic [CNT_WIDTH-1:0] o_issued
);

  localparam logic [6:0]           SEQ_W7   = 7'(SEQ_WIDTH);
  localparam logic [SEQ_WIDTH-1:0] ALL_ONES = {SEQ_WIDTH{1'b1}};
  localparam logic [SEQ_WIDTH-1:0] ONE_W    = {{(SEQ_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ONE_C    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] ZERO_C   = {CNT_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // (1<<len)-1 for a legal length; len == SEQ_WIDTH gives all ones.
  function automatic logic [SEQ_WIDTH-1:0] len_mask(input logic [6:0] len);
    return ALL_ONES >> (SEQ_W7 - len);
  endfunction

  // Mask applied to the running index: 2^M-1 where M is N or N-1.
  // With symmetry skipping and N=1 the shift equals SEQ_WIDTH, giving 0.
  function automatic logic [SEQ_WIDTH-1:0] index_mask(input logic [6:0] len);
`ifdef SEQ_GEN_SYM_SKIP_EN
    return ALL_ONES >> (SEQ_W7 - len + 7'd1);
`else
    return len_mask(len);
`endif
  endfunction

  // A length is usable only in 1..SEQ_WIDTH.
  function automatic logic len_legal(input logic [6:0] len);
    return (len != 7'd0) && (len <= SEQ_W7);
  endfunction

  state_t                 state_r;
  logic [SEQ_WIDTH-1:0]   idx_mask_r;
  logic [CNT_WIDTH-1:0]   remaining_r;

  logic                   start_legal_s;
  logic [SEQ_WIDTH-1:0]   start_mask_s;
  logic [SEQ_WIDTH-1:0]   start_idx_mask_s;
  logic [6:0]             start_offset_s;
  logic [SEQ_WIDTH-1:0]   next_idx_s;
  logic                   handshake_s;
  logic                   last_word_s;

  // Next-value helpers for the start decode and the running index.
  always_comb begin
    start_legal_s    = len_legal(i_len);
    start_mask_s     = len_mask(i_len);
    start_idx_mask_s = index_mask(i_len);
    start_offset_s   = SEQ_W7 - i_len;
    next_idx_s       = (o_seq + ONE_W) & idx_mask_r;
    handshake_s      = o_valid & i_ready;
    last_word_s      = (remaining_r == ONE_C);
  end

  // Control FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      idx_mask_r  <= {SEQ_WIDTH{1'b0}};
      remaining_r <= ZERO_C;
      o_seq       <= {SEQ_WIDTH{1'b0}};
      o_mask      <= {SEQ_WIDTH{1'b0}};
      o_offset    <= 7'd0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_err       <= 1'b0;
      o_issued    <= ZERO_C;
    end else begin
      // single-cycle pulses fall back to 0 unless re-asserted below
      o_done <= 1'b0;
      o_err  <= 1'b0;
      if (i_abort) begin
        // abort wins over start and handshake; o_issued is kept
        state_r <= ST_IDLE;
        o_valid <= 1'b0;
        o_busy  <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (i_start) begin
              if (start_legal_s) begin
                o_mask      <= start_mask_s;
                o_offset    <= start_offset_s;
                idx_mask_r  <= start_idx_mask_s;
                o_seq       <= i_base & start_idx_mask_s;
                remaining_r <= i_count;
                o_issued    <= ZERO_C;
                if (i_count == ZERO_C) begin
                  state_r <= ST_DONE;
                  o_done  <= 1'b1;
                end else begin
                  state_r <= ST_RUN;
                  o_valid <= 1'b1;
                  o_busy  <= 1'b1;
                end
              end else begin
                o_err <= 1'b1;
              end
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_RUN: begin
            if (handshake_s) begin
              o_seq       <= next_idx_s;
              remaining_r <= remaining_r - ONE_C;
              o_issued    <= o_issued + ONE_C;
              if (last_word_s) begin
                state_r <= ST_DONE;
                o_valid <= 1'b0;
                o_busy  <= 1'b0;
                o_done  <= 1'b1;
              end else begin
                state_r <= ST_RUN;
              end
            end else begin
              state_r <= ST_RUN;
            end
          end
          ST_DONE: begin
            state_r <= ST_IDLE;
          end
          default: begin
            state_r <= ST_IDLE;
            o_valid <= 1'b0;
            o_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen: the stimulus side pushes the words a run
// should produce (computed arithmetically as (base+i) mod 2^M) and the
// monitor pops them on every accepted handshake.
module tb_seq_gen;

  localparam int SW = 30;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_start = 1'b0;
  logic          i_abort = 1'b0;
  logic [6:0]    i_len = 7'd0;
  logic [SW-1:0] i_base = '0;
  logic [CW-1:0] i_count = '0;
  logic          i_ready = 1'b1;
  logic [SW-1:0] o_seq;
  logic [SW-1:0] o_mask;
  logic [6:0]    o_offset;
  logic          o_valid;
  logic          o_busy;
  logic          o_done;
  logic          o_err;
  logic [CW-1:0] o_issued;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int done_cnt = 0;
  bit rand_ready = 1'b0;

  logic [SW-1:0] exp_q[$];
  logic [SW-1:0] exp_mask = '0;
  logic [6:0]    exp_offset = 7'd0;

  logic          hold_v = 1'b0;
  logic [SW-1:0] hold_seq;
  logic [SW-1:0] hold_mask;
  logic [6:0]    hold_off;

  seq_gen #(.SEQ_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_len(i_len), .i_base(i_base), .i_count(i_count), .i_ready(i_ready),
    .o_seq(o_seq), .o_mask(o_mask), .o_offset(o_offset), .o_valid(o_valid),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_issued(o_issued)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares accepted words against the queue and checks holds.
  always @(negedge clk) begin
    logic [SW-1:0] e;
    if (!rst) begin
      hold_v <= 1'b0;
    end else begin
      if (hold_v) begin
        check(o_valid === 1'b1, "hold_valid", o_valid, 1);
        check(o_seq === hold_seq, "hold_seq", o_seq, hold_seq);
        check(o_mask === hold_mask, "hold_mask", o_mask, hold_mask);
        check(o_offset === hold_off, "hold_offset", o_offset, hold_off);
      end
      if (o_valid && i_ready && !i_abort) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_word", o_seq, 0);
        end else begin
          e = exp_q.pop_front();
          check(o_seq === e, "seq", o_seq, e);
          check(o_mask === exp_mask, "mask", o_mask, exp_mask);
          check(o_offset === exp_offset, "offset", o_offset, exp_offset);
        end
        hs_count <= hs_count + 1;
      end
      if (o_done) begin
        check(o_valid === 1'b0, "valid_with_done", o_valid, 0);
        done_cnt <= done_cnt + 1;
      end
      hold_v    <= o_valid && !i_ready && !i_abort;
      hold_seq  <= o_seq;
      hold_mask <= o_mask;
      hold_off  <= o_offset;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Reference: words are (base+i) mod 2^M, M = N (or N-1 with symmetry skip).
  task automatic load_model(input int len, input logic [SW-1:0] base, input int count);
    int m;
    logic [63:0] mm;
`ifdef SEQ_GEN_SYM_SKIP_EN
    m = len - 1;
`else
    m = len;
`endif
    mm = (64'd1 << m) - 64'd1;
    for (int i = 0; i < count; i++) exp_q.push_back(SW'((64'(base) + 64'(i)) & mm));
    exp_mask   = SW'((64'd1 << len) - 64'd1);
    exp_offset = 7'(SW - len);
  endtask

  task automatic do_start(input int len, input logic [SW-1:0] base, input int count);
    i_len   = 7'(len);
    i_base  = base;
    i_count = CW'(count);
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  task automatic finish_run(input int count, input int d0, input int h0,
                            input bit chk_lat, input bit busy_starts);
    int n;
    bit seen;
    n = 0;
    seen = o_done;
    if (count == 0) begin
      check(o_done === 1'b1, "zero_done", o_done, 1);
      check(o_valid === 1'b0, "zero_valid", o_valid, 0);
    end
    while (!seen && n < 5000) begin
      if (busy_starts && (o_busy || o_done) && $urandom_range(0, 7) == 0) begin
        i_start = 1'b1;
        i_len   = 7'($urandom_range(1, 30));
        i_base  = SW'($urandom);
        i_count = CW'($urandom_range(0, 9));
      end else begin
        i_start = 1'b0;
      end
      tick();
      n++;
      if (o_done) seen = 1'b1;
    end
    i_start = 1'b0;
    check(seen, "done_timeout", n, count);
    if (chk_lat && count > 0) check(n == count, "done_latency", n, count);
    check(o_valid === 1'b0, "valid_at_done", o_valid, 0);
    check(o_issued === CW'(count), "issued", o_issued, count);
    check(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    check(hs_count - h0 == count, "handshakes", hs_count - h0, count);
    tick();
    check(o_done === 1'b0, "done_width", o_done, 0);
    check(o_busy === 1'b0, "idle_after_done", o_busy, 0);
    check(done_cnt - d0 == 1, "done_count", done_cnt - d0, 1);
  endtask

  task automatic run_normal(input int len, input logic [SW-1:0] base, input int count,
                            input bit busy_starts);
    int d0, h0;
    d0 = done_cnt;
    h0 = hs_count;
    load_model(len, base, count);
    do_start(len, base, count);
    finish_run(count, d0, h0, !rand_ready, busy_starts);
  endtask

  task automatic run_illegal(input int len);
    int d0;
    d0 = done_cnt;
    do_start(len, SW'($urandom), 5);
    check(o_err === 1'b1, "err_pulse", o_err, 1);
    check(o_busy === 1'b0, "err_busy", o_busy, 0);
    check(o_valid === 1'b0, "err_valid", o_valid, 0);
    tick();
    check(o_err === 1'b0, "err_width", o_err, 0);
    check(o_busy === 1'b0, "err_stays_idle", o_busy, 0);
    check(done_cnt == d0, "err_no_done", done_cnt - d0, 0);
  endtask

  initial begin
    int d0, h0;
    // reset state
    repeat (3) tick();
    check(o_valid === 1'b0 && o_busy === 1'b0 && o_done === 1'b0 && o_err === 1'b0,
          "reset_flags", {o_valid, o_busy, o_done, o_err}, 0);
    check(o_seq === '0, "reset_seq", o_seq, 0);
    check(o_mask === '0, "reset_mask", o_mask, 0);
    check(o_offset === 7'd0, "reset_offset", o_offset, 0);
    check(o_issued === '0, "reset_issued", o_issued, 0);
    rst = 1'b1;
    tick();

    // basic run, ready always high
    i_ready = 1'b1;
    run_normal(20, 30'h0BEEF, 4, 1'b0);
    check(o_mask === 30'hFFFFF, "mask_n20", o_mask, 30'hFFFFF);
    check(o_offset === 7'd10, "offset_n20", o_offset, 10);

    // same run with ready low for 3 cycles on the second word
    d0 = done_cnt;
    h0 = hs_count;
    load_model(20, 30'h0BEEF, 4);
    do_start(20, 30'h0BEEF, 4);
    tick();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check(o_valid === 1'b1 && o_seq === 30'h0BEF0, "stall_word", o_seq, 30'h0BEF0);
      tick();
    end
    i_ready = 1'b1;
    finish_run(4, d0, h0, 1'b0, 1'b0);

    // wrap-around cases and zero count
    run_normal(4, 30'd14, 4, 1'b0);
    run_normal(4, 30'd6, 3, 1'b0);
    run_normal(1, 30'd1, 3, 1'b0);
    run_normal(30, 30'h3FFFFFFE, 4, 1'b0);
    run_normal(16, SW'($urandom), 0, 1'b0);
    run_illegal(31);
    run_illegal(0);

    // abort after two handshakes of a ten-word run
    d0 = done_cnt;
    h0 = hs_count;
    load_model(20, 30'h100, 2);
    do_start(20, 30'h100, 10);
    tick();
    tick();
    i_abort = 1'b1;
    tick();
    i_abort = 1'b0;
    check(o_valid === 1'b0, "abort_valid", o_valid, 0);
    check(o_busy === 1'b0, "abort_busy", o_busy, 0);
    check(o_issued === 32'd2, "abort_issued", o_issued, 2);
    check(hs_count - h0 == 2, "abort_handshakes", hs_count - h0, 2);
    repeat (3) tick();
    check(done_cnt == d0, "abort_no_done", done_cnt - d0, 0);
    check(o_issued === 32'd2, "abort_issued_kept", o_issued, 2);
    run_normal(20, 30'h100, 3, 1'b0);

    // abort has priority over a simultaneous legal start
    i_abort = 1'b1;
    do_start(8, 30'd5, 4);
    i_abort = 1'b0;
    check(o_busy === 1'b0 && o_valid === 1'b0 && o_done === 1'b0, "abort_vs_start",
          {o_busy, o_valid, o_done}, 0);

    // asynchronous reset mid-run
    load_model(12, 30'h55, 10);
    do_start(12, 30'h55, 10);
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    check(o_valid === 1'b0 && o_busy === 1'b0 && o_done === 1'b0 && o_err === 1'b0,
          "midrst_flags", {o_valid, o_busy, o_done, o_err}, 0);
    check(o_seq === '0 && o_mask === '0 && o_offset === 7'd0 && o_issued === '0,
          "midrst_data", o_seq, 0);
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();
    run_normal(12, 30'h55, 5, 1'b0);

    // randomized runs with random backpressure and ignored busy starts
    rand_ready = 1'b1;
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 0) run_illegal(0);
        else run_illegal(int'($urandom_range(31, 127)));
      end else begin
        run_normal(int'($urandom_range(1, 30)), SW'($urandom),
                   int'($urandom_range(0, 24)), 1'b1);
      end
    end
    rand_ready = 1'b0;
    i_ready = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Candidate-sequence generator for the LABS energy search. On a start command it enumerates a contiguous range of binary sequences of length N and streams each one with its derived mask and offset into the energy-calculation stage (`calc_e_buf`) over a valid/ready handshake. The block sits directly upstream of that stage: its outputs connect to the stage's `i_seq`/`i_mask`/`i_offset`/`i_valid`, and the stage's `o_ready` drives this block's `i_ready`.

## Interface
- `SEQ_WIDTH`, 30: sequence bus width; maximum N.
- `CNT_WIDTH`, 32: width of the range count and of the issued-word counter.

- `clk` in 1: single clock; all state on rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset), synchronous deassert at the source.
- `i_start` in 1: start command; sampled only in IDLE.
- `i_abort` in 1: abandon the current run.
- `i_len` in 7: sequence length N; legal range 1..SEQ_WIDTH.
- `i_base` in SEQ_WIDTH: first candidate value.
- `i_count` in CNT_WIDTH: number of candidates to emit.
- `i_ready` in 1: downstream can accept.
- `o_seq` out SEQ_WIDTH: candidate; bits at positions ≥ N are 0.
- `o_mask` out SEQ_WIDTH: (1<<N)-1.
- `o_offset` out 7: SEQ_WIDTH-N.
- `o_valid` out 1: `o_seq`/`o_mask`/`o_offset` are valid.
- `o_busy` out 1: high in RUN.
- `o_done` out 1: one-cycle pulse at normal completion.
- `o_err` out 1: one-cycle pulse when a start is rejected for an illegal `i_len`.
- `o_issued` out CNT_WIDTH: count of words accepted in the current or last run.

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **IDLE, `i_start`=1, `i_len` legal:**
  - Latch N, mask, offset, and remaining=`i_count`.
  - Load index = `i_base` mod 2^M. M=N by default; see Configuration.
  - Clear `o_issued`.
  - If `i_count`=0, go to DONE; otherwise go to RUN.
- **IDLE, `i_start`=1, `i_len`=0 or `i_len`>SEQ_WIDTH:** pulse `o_err` next cycle and stay in IDLE.
- **RUN:**
  - `o_valid`=1. `o_seq` = index zero-extended.
  - On `o_valid`&&`i_ready`: index ← (index+1) mod 2^M, remaining−1, `o_issued`+1.
  - When remaining was 1, go to DONE.
- **DONE:** `o_done`=1 for exactly one cycle, then go to IDLE.
- **Output hold:** while `o_valid`=1 and `i_ready`=0, all outputs hold stable.
- **Start while busy:** `i_start` in RUN or DONE is ignored.
- **`i_abort`:** in any state, go to IDLE next cycle. `o_valid` drops, no `o_done`, and `o_issued` keeps its value. `i_abort` has priority over the handshake and over `i_start` in the same cycle.
- **Wrap-around:** the index wraps modulo 2^M with no flag; `i_count` > 2^M re-emits values.
- **Reset values:** state IDLE, and every output 0 (`o_valid`, `o_seq`, `o_mask`, `o_offset`, `o_busy`, `o_done`, `o_err`, `o_issued`). Reset mid-run discards the run immediately and asynchronously.

## Timing
- All outputs are registered; nothing is combinational from input to output.
- Start latency: `i_start` sampled at edge k → `o_valid`=1 with the first word after edge k.
- Throughput: one word per cycle while `i_ready`=1.
- Completion: last handshake at edge j → `o_done`=1 after edge j, `o_valid`=0 in the same cycle, and IDLE after edge j+1.
- Zero count: `o_done` one cycle after the start edge, with no `o_valid`.
- Restart: `i_start` is accepted again in the first IDLE cycle, i.e. 2 cycles after the last handshake.
- `o_busy` equals (state==RUN).

## Configuration
- Macro: `SEQ_GEN_SYM_SKIP_EN`.
- **Defined:** exploits complement symmetry (E(s)=E(~s)).
  - M=N-1, so bit N-1 of `o_seq` is always 0 and only half the space is enumerated.
  - For N=1, M=0 and the index is always 0.
- **Undefined:** M=N; the full 2^N space is enumerated.

## Test plan
- N=20, base=0x0BEEF, count=4, `i_ready`=1 → `o_seq` 0x0BEEF, 0x0BEF0, 0x0BEF1, 0x0BEF2 on consecutive cycles. `o_mask`=0xFFFFF, `o_offset`=10, `o_done` on the next cycle, `o_issued`=4.
- Same run with `i_ready` low for 3 cycles on the second word → 0x0BEF0 held stable for 3 cycles, with no skips or duplicates.
- Wrap, macro undefined: N=4, base=14, count=4 → 0xE, 0xF, 0x0, 0x1.
- Wrap, macro defined: N=4, base=6, count=3 → 0x6, 0x7, 0x0.
- count=0 → `o_done` one cycle after start, `o_valid` never high. `i_len`=31 → `o_err` pulse, state stays IDLE.
- Abort and reset mid-run:
  - `i_abort` after 2 handshakes in a count=10 run → `o_valid`=0 next cycle, no `o_done`, `o_issued`=2.
  - `rst`=0 mid-run → all outputs 0 immediately.
  - A new start after either → clean run from base.
